// File: rtl/textmode_ctrl.sv
// rtl/textmode_ctrl.sv - text-buffer write-port arbiter with clear/scroll engine
module textmode_ctrl #(
    parameter int TEXT_W = 84,
    parameter int TEXT_H = 24,
    parameter int ADDRW  = 11,
    parameter int WORDW  = 32
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             cpu_we,
    input  logic [ADDRW-1:0] cpu_addr,
    input  logic [WORDW-1:0] cpu_din,
    output logic             cpu_ready,
    input  logic             cmd_clear,
    input  logic             cmd_scroll,
    input  logic [WORDW-1:0] fill_word,
    output logic             busy,
    output logic             done,
    output logic             ram_we,
    output logic [ADDRW-1:0] ram_waddr,
    output logic [WORDW-1:0] ram_wdata,
    output logic             ram_re,
    output logic [ADDRW-1:0] ram_raddr,
    input  logic [WORDW-1:0] ram_rdata
);
    localparam int N = TEXT_W * TEXT_H;
    localparam int M = TEXT_W * (TEXT_H - 1);
    localparam logic [ADDRW:0]   N_EXT  = (ADDRW+1)'(N);
    localparam logic [ADDRW-1:0] LAST_A = ADDRW'(N - 1);
    localparam logic [ADDRW-1:0] M_A    = ADDRW'(M);
    localparam logic [ADDRW-1:0] M_LAST = ADDRW'(M - 1);
    localparam logic [ADDRW-1:0] W_A    = ADDRW'(TEXT_W);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SC_RD, S_SC_WR, S_FILL, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [WORDW-1:0] fill_q, fill_d;
    logic             starved_q, starved_d;
    logic             eng_want, cpu_acc, eng_grant;

    // Outputs are forced quiet while reset is held so nothing reaches the RAM.
    always_comb begin
        eng_want  = (state_q == S_CLEAR) || (state_q == S_SC_WR) || (state_q == S_FILL);
        cpu_ready = !rst_sys && !(starved_q && eng_want);
        cpu_acc   = cpu_we && cpu_ready;
        eng_grant = !rst_sys && eng_want && !cpu_acc;

        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (cpu_acc) begin
            ram_we    = ({1'b0, cpu_addr} < N_EXT);
            ram_waddr = cpu_addr;
            ram_wdata = cpu_din;
        end else if (eng_grant) begin
            ram_we    = 1'b1;
            ram_waddr = addr_q;
            ram_wdata = (state_q == S_SC_WR) ? ram_rdata : fill_q;
        end

        ram_re    = !rst_sys && (state_q == S_SC_RD);
        ram_raddr = rst_sys ? '0 : addr_q + W_A;
        busy      = !rst_sys && (state_q != S_IDLE);
        done      = !rst_sys && (state_q == S_DONE);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        fill_d    = fill_q;
        starved_d = eng_want && cpu_acc;
        case (state_q)
            S_IDLE: begin
                if (cmd_clear || cmd_scroll) begin
                    state_d = cmd_clear ? S_CLEAR : S_SC_RD;
                    addr_d  = '0;
                    fill_d  = fill_word;
                end
            end
            S_CLEAR, S_FILL: begin
                if (eng_grant) begin
                    if (addr_q == LAST_A) state_d = S_DONE;
                    else                  addr_d  = addr_q + 1'b1;
                end
            end
            S_SC_RD: state_d = S_SC_WR;
            S_SC_WR: begin
                // The RAM holds read data while ram_re is low, so a lost grant just waits here.
                if (eng_grant) begin
                    if (addr_q == M_LAST) begin
                        addr_d  = M_A;
                        state_d = S_FILL;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_SC_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            fill_q    <= '0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            fill_q    <= fill_d;
            starved_q <= starved_d;
        end
    end
endmodule

// File: tb/tb_textmode_ctrl.sv
// tb/tb_textmode_ctrl.sv - scoreboard bench for textmode_ctrl
module tb_textmode_ctrl;
    localparam int W = 84;
    localparam int H = 24;
    localparam int N = W * H;
    localparam int M = W * (H - 1);

    typedef struct packed {
        logic [10:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_din;
    logic        cpu_ready;
    logic        cmd_clear, cmd_scroll;
    logic [31:0] fill_word;
    logic        busy, done;
    logic        ram_we, ram_re;
    logic [10:0] ram_waddr, ram_raddr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:2047];
    wr_t         exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    bit          sb_en = 1'b1;

    textmode_ctrl #(.TEXT_W(W), .TEXT_H(H), .ADDRW(11), .WORDW(32)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ready(cpu_ready),
        .cmd_clear(cmd_clear), .cmd_scroll(cmd_scroll), .fill_word(fill_word),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input int a, input logic [31:0] d);
        wr_t e;
        e.a = 11'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic run_until_done(input int start, input int limit, output int at);
        int c;
        c = start;
        at = -1;
        forever begin
            @(negedge clk_sys);
            if (done) begin
                at = c;
                return;
            end
            if (c >= limit) return;
            tick();
            c++;
        end
    endtask

    always @(negedge clk_sys) begin
        wr_t e;
        if (!rst_sys && done) done_cnt++;
        if (!rst_sys && ram_we) begin
            wr_cnt++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {53'd0, ram_waddr}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {53'd0, ram_waddr}, {53'd0, e.a});
                    check("wr_data", {32'd0, ram_wdata}, {32'd0, e.d});
                end
            end
        end
    end

    initial begin
        int at, w0, d0, acc;
        rst_sys = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        cmd_clear = 1'b0; cmd_scroll = 1'b0; fill_word = '0;
        repeat (3) tick();
        @(negedge clk_sys);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_waddr", ram_waddr, 0);
        check("rst_raddr", ram_raddr, 0);
        tick();
        rst_sys = 1'b0;

        // out-of-range CPU write is accepted but dropped; in-range write is immediate
        cpu_we = 1'b1; cpu_addr = 11'd2016; cpu_din = 32'hDEAD_BEEF;
        @(negedge clk_sys);
        check("oor_ready", cpu_ready, 1);
        check("oor_ram_we", ram_we, 0);
        tick();
        cpu_addr = 11'd5; cpu_din = 32'h1234_5678;
        push(5, 32'h1234_5678);
        @(negedge clk_sys);
        check("inr_ram_we", ram_we, 1);
        check("inr_waddr", ram_waddr, 5);
        tick();
        cpu_we = 1'b0;

        // clear with both strobes; a scroll strobe while busy must be ignored
        for (int i = 0; i < N; i++) push(i, 32'h0000_0A20);
        cmd_clear = 1'b1; cmd_scroll = 1'b1; fill_word = 32'h0000_0A20;
        tick();
        cmd_clear = 1'b0; cmd_scroll = 1'b0; fill_word = 32'h0;
        w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk_sys);
        check("clr_busy_k1", busy, 1);
        tick();
        cmd_scroll = 1'b1;
        tick();
        cmd_scroll = 1'b0;
        run_until_done(3, 5000, at);
        check("clr_done_cycle", at, N + 1);
        check("clr_writes", wr_cnt - w0, N);
        repeat (11) tick();
        @(negedge clk_sys);
        check("clr_done_pulses", done_cnt - d0, 1);
        check("clr_busy_after", busy, 0);
        tick();

        // preload word[i] = i, then scroll up with fill 0xFF
        for (int i = 0; i < N; i++) begin
            cpu_we = 1'b1; cpu_addr = 11'(i); cpu_din = 32'(i);
            push(i, 32'(i));
            tick();
        end
        cpu_we = 1'b0;
        for (int i = 0; i < M; i++) push(i, 32'(i + W));
        for (int i = M; i < N; i++) push(i, 32'hFF);
        cmd_scroll = 1'b1; fill_word = 32'hFF;
        tick();
        cmd_scroll = 1'b0;
        run_until_done(1, 10000, at);
        check("scr_done_cycle", at, 2 * M + W + 1);
        tick();
        check("scr_mem0", mem[0], W);
        check("scr_mem_last_row", mem[M - 1], N - 1);
        check("scr_mem_fill0", mem[M], 32'hFF);
        check("scr_mem_fill_end", mem[N - 1], 32'hFF);

        // continuous CPU traffic during a clear: CPU and engine alternate
        for (int i = 0; i < N; i++) begin
            push((i * 7) % N, 32'hC000_0000 | 32'(i));
            push(i, 32'h55);
        end
        cmd_clear = 1'b1; fill_word = 32'h55;
        tick();
        cmd_clear = 1'b0;
        acc = 0; at = -1;
        for (int c = 1; c <= 3 * N && at < 0; c++) begin
            cpu_we = (acc < N);
            cpu_addr = 11'((acc * 7) % N);
            cpu_din = 32'hC000_0000 | 32'(acc);
            @(negedge clk_sys);
            if (c <= 4) check($sformatf("fair_ready_c%0d", c), cpu_ready, c % 2);
            if (cpu_we && cpu_ready) acc++;
            if (done) at = c;
            tick();
        end
        cpu_we = 1'b0;
        check("fair_done_cycle", at, 2 * N + 1);
        check("fair_cpu_accepts", acc, N);
        check("sb_drained", exp_q.size(), 0);

        // reset in the middle of a scroll aborts with no further writes or done
        sb_en = 1'b0;
        cmd_scroll = 1'b1; fill_word = 32'h77;
        tick();
        cmd_scroll = 1'b0;
        repeat (100) tick();
        rst_sys = 1'b1;
        tick();
        @(negedge clk_sys);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ram_we", ram_we, 0);
        check("mid_rst_ram_re", ram_re, 0);
        check("mid_rst_done", done, 0);
        tick();
        rst_sys = 1'b0;
        w0 = wr_cnt; d0 = done_cnt;
        repeat (50) tick();
        @(negedge clk_sys);
        check("post_rst_writes", wr_cnt - w0, 0);
        check("post_rst_done", done_cnt - d0, 0);
        check("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
